// File: rtl/sketch_update_ctrl.sv
// Count-min sketch update sequencer: per key, N_HASH read-modify-writes on a shared 1-cycle-latency RAM, then min estimate (2*N_HASH+1 cycles accept->est_valid).
// upd_ready only in IDLE with no clear pending; full clear sweep of N_HASH*SKETCH_DEPTH cycles. Optional macro SKETCH_EPOCH_EN adds periodic auto-clear.
module sketch_update_ctrl #(
    parameter int N_HASH       = 4,
    parameter int SKETCH_DEPTH = 256,
    parameter int KEY_WIDTH    = 32,
    parameter int CNT_WIDTH    = 16,
    parameter int EPOCH_CYCLES = 1000000,
    localparam int IW = $clog2(SKETCH_DEPTH),
    localparam int AW = $clog2(N_HASH * SKETCH_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 upd_valid,
    output logic                 upd_ready,
    input  logic [KEY_WIDTH-1:0] upd_key,
    input  logic [CNT_WIDTH-1:0] upd_inc,
    input  logic                 clear_req,
    output logic [AW-1:0]        mem_addr,
    output logic                 mem_we,
    output logic [CNT_WIDTH-1:0] mem_wdata,
    input  logic [CNT_WIDTH-1:0] mem_rdata,
    output logic                 est_valid,
    output logic [CNT_WIDTH-1:0] est_count,
    output logic                 busy
);

    localparam int RW    = (N_HASH > 1) ? $clog2(N_HASH) : 1;
    localparam int NSL   = (KEY_WIDTH + IW - 1) / IW;
    localparam int TOTAL = N_HASH * SKETCH_DEPTH;

    typedef enum logic [2:0] {IDLE, READ, WRITE, DONE, CLEAR} state_t;

    state_t               state, state_nxt;
    logic [KEY_WIDTH-1:0] key_q;
    logic [CNT_WIDTH-1:0] inc_q;
    logic [CNT_WIDTH-1:0] min_q;
    logic [CNT_WIDTH-1:0] est_q;
    logic [RW-1:0]        row_q;
    logic [AW-1:0]        clr_addr_q;
    logic                 clr_pend_q;

    logic                 epoch_wrap;
    logic                 clr_now;
    logic                 last_row;
    logic                 clr_last;
    logic [AW-1:0]        row_addr [N_HASH];
    logic [AW-1:0]        cur_addr;
    logic [CNT_WIDTH:0]   sum_wide;
    logic [CNT_WIDTH-1:0] sum_sat;
    logic [CNT_WIDTH-1:0] min_nxt;

    // Each row has a fixed rotation, so every row's address is computed in parallel and muxed by row_q.
    for (genvar g = 0; g < N_HASH; g++) begin : g_row
        localparam int SH   = (7 * g) % KEY_WIDTH;
        localparam int BASE = g * SKETCH_DEPTH;

        logic [KEY_WIDTH-1:0] rot;
        logic [NSL*IW-1:0]    padded;
        logic [IW-1:0]        idx;

        always_comb begin
            rot = '0;
            for (int b = 0; b < KEY_WIDTH; b++) begin
                rot[(b + SH) % KEY_WIDTH] = key_q[b];
            end
            padded = (NSL*IW)'(rot);
            idx    = '0;
            for (int s = 0; s < NSL; s++) begin
                idx = idx ^ padded[s*IW +: IW];
            end
        end

        assign row_addr[g] = AW'(BASE) | AW'(idx);
    end

    always_comb begin
        cur_addr = '0;
        for (int i = 0; i < N_HASH; i++) begin
            if (row_q == RW'(i)) begin
                cur_addr = row_addr[i];
            end
        end
    end

    assign sum_wide = {1'b0, mem_rdata} + {1'b0, inc_q};
    assign sum_sat  = sum_wide[CNT_WIDTH] ? '1 : sum_wide[CNT_WIDTH-1:0];
    assign min_nxt  = (sum_sat < min_q) ? sum_sat : min_q;
    assign last_row = (row_q == RW'(N_HASH - 1));
    assign clr_last = (clr_addr_q == AW'(TOTAL - 1));

`ifdef SKETCH_EPOCH_EN
    localparam int EW = (EPOCH_CYCLES > 1) ? $clog2(EPOCH_CYCLES) : 1;

    logic [EW-1:0] epoch_q;

    assign epoch_wrap = (epoch_q == EW'(EPOCH_CYCLES - 1));

    // Free-running: keeps counting through CLEAR so the epoch period stays fixed.
    always_ff @(posedge clk) begin
        if (rst) begin
            epoch_q <= '0;
        end else if (epoch_wrap) begin
            epoch_q <= '0;
        end else begin
            epoch_q <= epoch_q + EW'(1);
        end
    end
`else
    assign epoch_wrap = 1'b0 && (EPOCH_CYCLES > 0);
`endif

    assign clr_now = clear_req | epoch_wrap;

    always_comb begin
        state_nxt = state;
        upd_ready = 1'b0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        est_valid = 1'b0;
        busy      = 1'b0;
        if (!rst) begin
            busy = (state != IDLE);
            case (state)
                IDLE: begin
                    // A clear arriving alongside an update wins; the update must wait.
                    if (clr_pend_q || clr_now) begin
                        state_nxt = CLEAR;
                    end else begin
                        upd_ready = 1'b1;
                        if (upd_valid) begin
                            state_nxt = READ;
                        end
                    end
                end
                READ: begin
                    mem_addr  = cur_addr;
                    state_nxt = WRITE;
                end
                WRITE: begin
                    mem_addr  = cur_addr;
                    mem_we    = 1'b1;
                    mem_wdata = sum_sat;
                    state_nxt = last_row ? DONE : READ;
                end
                DONE: begin
                    est_valid = 1'b1;
                    state_nxt = IDLE;
                end
                CLEAR: begin
                    mem_addr  = clr_addr_q;
                    mem_we    = 1'b1;
                    if (clr_last) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign est_count = (!rst && state == DONE) ? min_q : est_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            key_q      <= '0;
            inc_q      <= '0;
            min_q      <= '1;
            est_q      <= '0;
            row_q      <= '0;
            clr_addr_q <= '0;
            clr_pend_q <= 1'b0;
        end else begin
            state <= state_nxt;

            if (state == IDLE && state_nxt == CLEAR) begin
                clr_pend_q <= 1'b0;
                clr_addr_q <= '0;
            end else if (clr_now && (state == READ || state == WRITE || state == DONE)) begin
                clr_pend_q <= 1'b1;
            end

            if (state == IDLE && state_nxt == READ) begin
                key_q <= upd_key;
                inc_q <= upd_inc;
                row_q <= '0;
                min_q <= '1;
            end

            if (state == WRITE) begin
                min_q <= min_nxt;
                if (!last_row) begin
                    row_q <= row_q + RW'(1);
                end
            end

            if (state == DONE) begin
                est_q <= min_q;
            end

            if (state == CLEAR) begin
                clr_addr_q <= clr_addr_q + AW'(1);
            end
        end
    end

endmodule
